// File: rtl/eth_rmii_rx_front.sv
// RMII receive front end: samples Rxd/Crs_DV, decodes CRS_DV with end-of-frame toggling,
// strips preamble/SFD and packs LSB-first dibits into bytes with SOF and frame-end status.
module eth_rmii_rx_front #(
   parameter int pMAX_BYTES = 1522,
   parameter int pLEN_WIDTH = 11
) (
   input  logic                  Clk,
   input  logic                  Rst_N,
   input  logic [1:0]            Rxd,
   input  logic                  Crs_DV,
   output logic [7:0]            Byte_Data,
   output logic                  Byte_Valid,
   output logic                  Byte_Sof,
   output logic                  Frame_Done,
   output logic [pLEN_WIDTH-1:0] Frame_Len,
   output logic                  Frame_Err
);

   localparam logic [pLEN_WIDTH-1:0] LP_MAX_LEN = pLEN_WIDTH'(pMAX_BYTES);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_SFD_WAIT,
      ST_DATA,
      ST_DISCARD
   } state_t;

   logic [1:0]            rRxd_q;
   logic                  rCrs_q;
   logic [1:0]            rRxd_d;
   logic                  rCrs_d;
   logic                  rCrs_prev;
   state_t                r_state;
   logic [5:0]            r_shift;
   logic [1:0]            r_dcnt;
   logic [pLEN_WIDTH-1:0] r_len;
   logic                  r_ovf;
   logic [7:0]            r_pack_data;
   logic                  r_pack_vld;
   logic                  r_pack_sof;
   logic                  r_done_p;

   logic                  w_end;
   logic                  w_rise;
   logic [7:0]            w_byte;

   assign w_end  = ~rCrs_d & ~rCrs_q;
   assign w_rise = ~rCrs_prev & rCrs_q;
   assign w_byte = {rRxd_d, r_shift};

   // Carrier is presumed present out of reset, so only a genuine low-to-high edge starts a frame.
   always_ff @(posedge Clk or negedge Rst_N) begin
      if (!Rst_N) begin
         rRxd_q    <= 2'b00;
         rCrs_q    <= 1'b1;
         rRxd_d    <= 2'b00;
         rCrs_d    <= 1'b1;
         rCrs_prev <= 1'b1;
      end else begin
         rRxd_q    <= Rxd;
         rCrs_q    <= Crs_DV;
         rRxd_d    <= rRxd_q;
         rCrs_d    <= rCrs_q;
         rCrs_prev <= rCrs_q;
      end
   end

   // Decision and pack: rRxd_d is valid unless both rCrs_d and rCrs_q are low.
   always_ff @(posedge Clk or negedge Rst_N) begin
      if (!Rst_N) begin
         r_state     <= ST_IDLE;
         r_shift     <= 6'd0;
         r_dcnt      <= 2'd0;
         r_len       <= '0;
         r_ovf       <= 1'b0;
         r_pack_data <= 8'h00;
         r_pack_vld  <= 1'b0;
         r_pack_sof  <= 1'b0;
         r_done_p    <= 1'b0;
      end else begin
         r_pack_vld <= 1'b0;
         r_pack_sof <= 1'b0;
         r_done_p   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_len  <= '0;
               r_dcnt <= 2'd0;
               r_ovf  <= 1'b0;
               if (w_rise) r_state <= ST_PREAMBLE;
            end
            ST_PREAMBLE: begin
               if (w_end) begin
                  r_state <= ST_IDLE;
               end else begin
                  case (rRxd_d)
                     2'b00:   r_state <= ST_PREAMBLE;
                     2'b01:   r_state <= ST_SFD_WAIT;
                     default: r_state <= ST_DISCARD;
                  endcase
               end
            end
            ST_SFD_WAIT: begin
               if (w_end) begin
                  r_state <= ST_IDLE;
               end else begin
                  case (rRxd_d)
                     2'b01:   r_state <= ST_SFD_WAIT;
                     2'b11:   r_state <= ST_DATA;
                     default: r_state <= ST_DISCARD;
                  endcase
               end
            end
            ST_DATA: begin
               if (w_end) begin
                  r_state  <= ST_IDLE;
                  r_done_p <= 1'b1;
               end else begin
                  r_shift <= {rRxd_d, r_shift[5:2]};
                  r_dcnt  <= r_dcnt + 2'd1;
                  if (r_dcnt == 2'd3) begin
                     if (r_len != LP_MAX_LEN) begin
                        r_pack_data <= w_byte;
                        r_pack_vld  <= 1'b1;
                        r_pack_sof  <= (r_len == '0);
                        r_len       <= r_len + 1'b1;
                     end else begin
                        r_ovf <= 1'b1;
                     end
                  end
               end
            end
            ST_DISCARD: begin
               if (w_end) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Output register; frame status is read here before IDLE clears the counters.
   always_ff @(posedge Clk or negedge Rst_N) begin
      if (!Rst_N) begin
         Byte_Data  <= 8'h00;
         Byte_Valid <= 1'b0;
         Byte_Sof   <= 1'b0;
         Frame_Done <= 1'b0;
         Frame_Len  <= '0;
         Frame_Err  <= 1'b0;
      end else begin
         Byte_Valid <= r_pack_vld;
         Byte_Sof   <= r_pack_sof;
         Frame_Done <= r_done_p;
         if (r_pack_vld) Byte_Data <= r_pack_data;
         if (r_done_p) begin
            Frame_Len <= r_len;
            Frame_Err <= (r_dcnt != 2'd0) | r_ovf | (r_len == '0);
         end
      end
   end

endmodule

// File: tb/tb_eth_rmii_rx_front.sv
// Bench for eth_rmii_rx_front: directed vector table, reset-in-frame sequence and
// randomized frames scored against a frame-level expectation model.
`timescale 1ns/1ps
module tb_eth_rmii_rx_front;

   localparam int MAXB = 16;
   localparam int LW   = 11;

   logic          Clk = 1'b0;
   logic          Rst_N;
   logic [1:0]    Rxd;
   logic          Crs_DV;
   logic [7:0]    Byte_Data;
   logic          Byte_Valid;
   logic          Byte_Sof;
   logic          Frame_Done;
   logic [LW-1:0] Frame_Len;
   logic          Frame_Err;

   eth_rmii_rx_front #(.pMAX_BYTES(MAXB), .pLEN_WIDTH(LW)) dut (
      .Clk(Clk), .Rst_N(Rst_N), .Rxd(Rxd), .Crs_DV(Crs_DV),
      .Byte_Data(Byte_Data), .Byte_Valid(Byte_Valid), .Byte_Sof(Byte_Sof),
      .Frame_Done(Frame_Done), .Frame_Len(Frame_Len), .Frame_Err(Frame_Err)
   );

   always #10 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   typedef struct { logic [7:0] data; bit sof; int t; } byte_ev_t;
   typedef struct { int len; bit err; int t; } done_ev_t;
   typedef struct {
      int nbytes; int extra; bit toggle; bit false_car;
      int exp_emit; int exp_len; bit exp_err; bit exp_done;
   } vec_t;

   byte_ev_t   obs_b[$], exp_b[$];
   done_ev_t   obs_d[$], exp_d[$];
   vec_t       tbl[9];
   logic [7:0] pay[0:31];
   int         t4[0:31];
   int         t_end;
   int         n_checks = 0;
   int         n_fail   = 0;
   int         glitch   = 0;
   int         last_len = 0;
   bit         last_err = 1'b0;

   always @(negedge Clk) begin
      if (Byte_Valid) obs_b.push_back('{Byte_Data, Byte_Sof, cyc});
      if (Frame_Done) obs_d.push_back('{int'(Frame_Len), Frame_Err, cyc});
      if (Byte_Valid && Frame_Done) glitch++;
      if (Byte_Sof && !Byte_Valid) glitch++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, actual cycle %0d, required finish", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic crs, input logic [1:0] d);
      @(negedge Clk);
      Crs_DV = crs;
      Rxd    = d;
   endtask

   // lead low cycles, preamble, SFD, n bytes (optionally toggled), extra dibits, one low.
   task automatic send_frame(input int n, input int extra, input bit toggle, input int lead);
      logic [7:0] b;
      logic       crs;
      int         m;
      repeat (lead) drive(1'b0, 2'($urandom_range(0, 3)));
      repeat (28) drive(1'b1, 2'b01);
      repeat (3) drive(1'b1, 2'b01);
      drive(1'b1, 2'b11);
      for (int k = 0; k < n; k++) begin
         b = pay[k];
         for (int j = 0; j < 4; j++) begin
            crs = 1'b1;
            if (toggle && k >= n - 2) begin
               m   = (k - (n - 2)) * 4 + j;
               crs = (m % 2 == 1);
            end
            drive(crs, b[2*j +: 2]);
         end
         t4[k] = cyc;
      end
      for (int e = 0; e < extra; e++) drive(1'b1, 2'($urandom_range(0, 3)));
      drive(1'b0, 2'($urandom_range(0, 3)));
      t_end = cyc;
   endtask

   task automatic send_false(input int lead);
      repeat (lead) drive(1'b0, 2'b00);
      drive(1'b1, 2'b00);
      drive(1'b1, 2'b00);
      drive(1'b1, 2'b10);
      repeat (6) drive(1'b1, 2'b01);
      drive(1'b1, 2'b11);
      repeat (8) drive(1'b1, 2'($urandom_range(0, 3)));
      drive(1'b0, 2'b00);
   endtask

   task automatic expect_frame(input int emit, input int len, input bit err);
      for (int k = 0; k < emit; k++) exp_b.push_back('{pay[k], (k == 0), t4[k] + 4});
      exp_d.push_back('{len, err, t_end + 4});
      last_len = len;
      last_err = err;
   endtask

   task automatic drain(input string tag);
      repeat (8) drive(1'b0, 2'b00);
      check($sformatf("%s byte_count", tag), obs_b.size(), exp_b.size());
      for (int i = 0; i < obs_b.size() && i < exp_b.size(); i++) begin
         check($sformatf("%s byte%0d data", tag, i), obs_b[i].data, exp_b[i].data);
         check($sformatf("%s byte%0d sof", tag, i), obs_b[i].sof, exp_b[i].sof);
         check($sformatf("%s byte%0d cycle", tag, i), obs_b[i].t, exp_b[i].t);
      end
      check($sformatf("%s done_count", tag), obs_d.size(), exp_d.size());
      for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++) begin
         check($sformatf("%s done%0d len", tag, i), obs_d[i].len, exp_d[i].len);
         check($sformatf("%s done%0d err", tag, i), obs_d[i].err, exp_d[i].err);
         check($sformatf("%s done%0d cycle", tag, i), obs_d[i].t, exp_d[i].t);
      end
      check($sformatf("%s overlap_or_stray_sof", tag), glitch, 0);
      check($sformatf("%s len_hold", tag), Frame_Len, last_len);
      check($sformatf("%s err_hold", tag), Frame_Err, last_err);
      obs_b.delete(); exp_b.delete(); obs_d.delete(); exp_d.delete();
      glitch = 0;
   endtask

   initial begin
      int  n, extra, lead, emit;
      bit  tog, err;
      logic [7:0] b;

      tbl[0] = '{3,  0, 1'b0, 1'b0, 3,  3,  1'b0, 1'b1};
      tbl[1] = '{3,  0, 1'b1, 1'b0, 3,  3,  1'b0, 1'b1};
      tbl[2] = '{2,  2, 1'b0, 1'b0, 2,  2,  1'b1, 1'b1};
      tbl[3] = '{0,  0, 1'b0, 1'b1, 0,  0,  1'b0, 1'b0};
      tbl[4] = '{3,  0, 1'b0, 1'b0, 3,  3,  1'b0, 1'b1};
      tbl[5] = '{20, 0, 1'b0, 1'b0, 16, 16, 1'b1, 1'b1};
      tbl[6] = '{16, 0, 1'b0, 1'b0, 16, 16, 1'b0, 1'b1};
      tbl[7] = '{0,  0, 1'b0, 1'b0, 0,  0,  1'b1, 1'b1};
      tbl[8] = '{1,  1, 1'b0, 1'b0, 1,  1,  1'b1, 1'b1};
      pay[0] = 8'h12;
      pay[1] = 8'h34;
      pay[2] = 8'hAB;
      for (int k = 3; k < 32; k++) pay[k] = 8'(k * 37 + 5);

      Rst_N = 1'b0; Crs_DV = 1'b0; Rxd = 2'b00;
      repeat (3) @(negedge Clk);
      check("reset Byte_Data", Byte_Data, 0);
      check("reset Byte_Valid", Byte_Valid, 0);
      check("reset Byte_Sof", Byte_Sof, 0);
      check("reset Frame_Done", Frame_Done, 0);
      check("reset Frame_Len", Frame_Len, 0);
      check("reset Frame_Err", Frame_Err, 0);
      Rst_N = 1'b1;

      for (int i = 0; i < 9; i++) begin
         if (tbl[i].false_car) begin
            send_false(3);
         end else begin
            send_frame(tbl[i].nbytes, tbl[i].extra, tbl[i].toggle, 3);
            if (tbl[i].exp_done) expect_frame(tbl[i].exp_emit, tbl[i].exp_len, tbl[i].exp_err);
         end
         drain($sformatf("vec%0d", i));
      end

      // Reset during the second data byte, released while the carrier is still up.
      repeat (3) drive(1'b0, 2'b00);
      repeat (31) drive(1'b1, 2'b01);
      drive(1'b1, 2'b11);
      b = pay[0];
      for (int j = 0; j < 4; j++) drive(1'b1, b[2*j +: 2]);
      b = pay[1];
      drive(1'b1, b[1:0]);
      drive(1'b1, b[3:2]);
      @(negedge Clk);
      Rxd   = b[5:4];
      Rst_N = 1'b0;
      #1;
      check("midrst Byte_Data", Byte_Data, 0);
      check("midrst Byte_Valid", Byte_Valid, 0);
      check("midrst Byte_Sof", Byte_Sof, 0);
      check("midrst Frame_Done", Frame_Done, 0);
      check("midrst Frame_Len", Frame_Len, 0);
      check("midrst Frame_Err", Frame_Err, 0);
      drive(1'b1, 2'b10);
      drive(1'b1, 2'b01);
      Rst_N = 1'b1;
      repeat (31) drive(1'b1, 2'b01);
      drive(1'b1, 2'b11);
      for (int k = 0; k < 3; k++) begin
         b = pay[k];
         for (int j = 0; j < 4; j++) drive(1'b1, b[2*j +: 2]);
      end
      drive(1'b0, 2'b00);
      last_len = 0;
      last_err = 1'b0;
      drain("midrst_quiet");
      send_frame(3, 0, 1'b0, 1);
      expect_frame(3, 3, 1'b0);
      drain("midrst_recover");

      // Randomized frames, back-to-back with short gaps, against the frame-level model.
      for (int r = 0; r < 16; r++) begin
         lead = $urandom_range(1, 4);
         if ($urandom_range(0, 5) == 0) begin
            send_false(lead);
         end else begin
            n     = $urandom_range(0, 22);
            extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            tog   = (extra == 0 && n >= 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            for (int k = 0; k < n; k++) pay[k] = 8'($urandom);
            send_frame(n, extra, tog, lead);
            emit = (n > MAXB) ? MAXB : n;
            err  = (extra != 0) || (n > MAXB) || (n == 0);
            expect_frame(emit, emit, err);
            if (r % 4 == 3) drain($sformatf("rand%0d", r));
         end
      end
      drain("rand_end");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
